// File: rtl/bram_sdp_bist_pkg.sv
// ----------------------------------------------------------------------------
// bram_sdp_bist_pkg
// Shared types and helpers for the SDP block-RAM self-test initiator.
//   state_t   : controller states
//   PAT_CONST : constant OR-ed into every test word
//   PAT_SHIFT : left shift applied to the address copy inside the test word
//   pat()     : test word for an address, computed at PAT_WIDTH bits; callers
//               zero-extend the address in and truncate the result to their
//               own data width with a size cast.
// ----------------------------------------------------------------------------
package bram_sdp_bist_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        READ  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [19:0] PAT_CONST = 20'h55000;
    localparam int          PAT_SHIFT = 20;
    localparam int          PAT_WIDTH = 64;

    // Wide enough that the shifted address copy is never lost before the
    // caller truncates to its RAM data width.
    function automatic logic [PAT_WIDTH-1:0] pat(input logic [PAT_WIDTH-1:0] addr);
        return addr | (addr << PAT_SHIFT) | PAT_WIDTH'(PAT_CONST);
    endfunction

endpackage

// File: rtl/bram_sdp_bist_checker.sv
// ----------------------------------------------------------------------------
// bram_sdp_bist_checker
// Aligns each issued read with the RAM's returned data and scores it.
//   clk, rst   : clock, asynchronous active-high reset
//   clear      : start of a new run; clears the result registers
//   rce, ra    : read enable / address as registered onto the RAM port
//   rq         : RAM read data, valid READ_LATENCY cycles after rce
//   err_cnt    : saturating count of mismatching reads
//   fail_vld   : at least one mismatch recorded since clear
//   fail_addr  : address of the first mismatch since clear
// ----------------------------------------------------------------------------
module bram_sdp_bist_checker
    import bram_sdp_bist_pkg::*;
#(
    parameter int ADDR_WIDTH    = 9,
    parameter int DATA_WIDTH    = 32,
    parameter int READ_LATENCY  = 1,
    parameter int ERR_CNT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     rce,
    input  logic [ADDR_WIDTH-1:0]    ra,
    input  logic [DATA_WIDTH-1:0]    rq,
    output logic [ERR_CNT_WIDTH-1:0] err_cnt,
    output logic                     fail_vld,
    output logic [ADDR_WIDTH-1:0]    fail_addr
);

    logic [READ_LATENCY-1:0] pipe_vld;
    logic [ADDR_WIDTH-1:0]   pipe_addr [READ_LATENCY];
    logic [DATA_WIDTH-1:0]   exp_q;
    logic                    mismatch;

    assign exp_q    = DATA_WIDTH'(pat(PAT_WIDTH'(pipe_addr[READ_LATENCY-1])));
    assign mismatch = pipe_vld[READ_LATENCY-1] && (rq != exp_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the address pipeline is a handful of flops, not a RAM, so
            // it is reset like any other register; a real memory array would
            // not be.
            pipe_vld <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_addr[i] <= '0;
            end
            err_cnt   <= '0;
            fail_vld  <= 1'b0;
            fail_addr <= '0;
        end else begin
            // NOTE: every clocked assignment is non-blocking so the shift
            // stages read the pre-edge value of their neighbour.
            pipe_vld[0]  <= rce;
            pipe_addr[0] <= ra;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_vld[i]  <= pipe_vld[i-1];
                pipe_addr[i] <= pipe_addr[i-1];
            end

            if (clear) begin
                err_cnt   <= '0;
                fail_vld  <= 1'b0;
                fail_addr <= '0;
            end else if (mismatch) begin
                if (err_cnt != {ERR_CNT_WIDTH{1'b1}}) begin
                    err_cnt <= err_cnt + ERR_CNT_WIDTH'(1);
                end
                if (!fail_vld) begin
                    fail_vld  <= 1'b1;
                    fail_addr <= pipe_addr[READ_LATENCY-1];
                end
            end
        end
    end

endmodule

// File: rtl/bram_sdp_bist.sv
// ----------------------------------------------------------------------------
// bram_sdp_bist
// Self-test initiator for a simple-dual-port block RAM. A start pulse writes
// pat(a) to every tested address, reads every address back, and scores the
// returned data.
//   clk, rst             : clock, asynchronous active-high reset
//   start                : run request, honoured only in IDLE or DONE
//   busy, done, pass     : run status; pass is meaningful while done
//   err_cnt              : saturating mismatch count
//   fail_vld, fail_addr  : first mismatching address of the run
//   wce, wa, wd          : RAM write port (registered)
//   rce, ra              : RAM read port (registered)
//   rq                   : RAM read data
// ----------------------------------------------------------------------------
module bram_sdp_bist
    import bram_sdp_bist_pkg::*;
#(
    parameter int ADDR_WIDTH    = 9,
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_INCR     = 1,
    parameter int READ_LATENCY  = 1,
    parameter int ERR_CNT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic [ERR_CNT_WIDTH-1:0] err_cnt,
    output logic                     fail_vld,
    output logic [ADDR_WIDTH-1:0]    fail_addr,
    output logic                     wce,
    output logic [ADDR_WIDTH-1:0]    wa,
    output logic [DATA_WIDTH-1:0]    wd,
    output logic                     rce,
    output logic [ADDR_WIDTH-1:0]    ra,
    input  logic [DATA_WIDTH-1:0]    rq
);

    localparam int DRAIN_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] addr, addr_nxt;   // address currently on wa/ra
    logic [ADDR_WIDTH:0]   addr_inc;
    logic                  last;
    logic [DRAIN_W-1:0]    drain_cnt, drain_nxt;
    logic                  wce_nxt, rce_nxt, start_ok;

    // One extra bit: the carry out marks the last tested address, so a phase
    // never wraps back to 0.
    assign addr_inc = {1'b0, addr} + (ADDR_WIDTH+1)'(ADDR_INCR);
    assign last     = addr_inc[ADDR_WIDTH];

    always_comb begin
        // NOTE: defaults first, so every path assigns every signal and no
        // latch is inferred.
        state_nxt = state;
        addr_nxt  = addr;
        drain_nxt = drain_cnt;
        wce_nxt   = 1'b0;
        rce_nxt   = 1'b0;
        start_ok  = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    start_ok  = 1'b1;
                    state_nxt = WRITE;
                    addr_nxt  = '0;
                    wce_nxt   = 1'b1;
                end
            end
            WRITE: begin
                if (last) begin
                    state_nxt = READ;
                    addr_nxt  = '0;
                    rce_nxt   = 1'b1;
                end else begin
                    addr_nxt = addr_inc[ADDR_WIDTH-1:0];
                    wce_nxt  = 1'b1;
                end
            end
            READ: begin
                if (last) begin
                    state_nxt = DRAIN;
                    drain_nxt = '0;
                end else begin
                    addr_nxt = addr_inc[ADDR_WIDTH-1:0];
                    rce_nxt  = 1'b1;
                end
            end
            DRAIN: begin
                // Wait out the read latency so the last rq is scored on the
                // same edge that raises done.
                if (drain_cnt == DRAIN_W'(READ_LATENCY - 1)) begin
                    state_nxt = DONE;
                end else begin
                    drain_nxt = drain_cnt + DRAIN_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            addr      <= '0;
            drain_cnt <= '0;
            wce       <= 1'b0;
            rce       <= 1'b0;
            wa        <= '0;
            wd        <= '0;
            ra        <= '0;
        end else begin
            state     <= state_nxt;
            addr      <= addr_nxt;
            drain_cnt <= drain_nxt;
            wce       <= wce_nxt;
            rce       <= rce_nxt;
            // Address/data registers only load alongside their enable and
            // otherwise hold.
            if (wce_nxt) begin
                wa <= addr_nxt;
                wd <= DATA_WIDTH'(pat(PAT_WIDTH'(addr_nxt)));
            end
            if (rce_nxt) begin
                ra <= addr_nxt;
            end
        end
    end

    assign busy = (state == WRITE) || (state == READ) || (state == DRAIN);
    assign done = (state == DONE);
    assign pass = done && (err_cnt == '0);

    bram_sdp_bist_checker #(
        .ADDR_WIDTH    (ADDR_WIDTH),
        .DATA_WIDTH    (DATA_WIDTH),
        .READ_LATENCY  (READ_LATENCY),
        .ERR_CNT_WIDTH (ERR_CNT_WIDTH)
    ) u_checker (
        .clk       (clk),
        .rst       (rst),
        .clear     (start_ok),
        .rce       (rce),
        .ra        (ra),
        .rq        (rq),
        .err_cnt   (err_cnt),
        .fail_vld  (fail_vld),
        .fail_addr (fail_addr)
    );

endmodule
